// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserialiser with a one-word output holding register.
//
// Collects WIDTH serial bits into a word (first bit in the MSB or the LSB, chosen by
// MSB_FIRST). When a word completes, it is copied into a holding register and presented
// with a valid/ready handshake. The serial side stalls only on the final bit of a word,
// and only while the previous word is still held. Because of this, no word is ever lost.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   rst        in   synchronous active-high reset
//   din        in   serial data bit
//   din_valid  in   din carries a bit this cycle
//   din_ready  out  deserialiser accepts din this cycle (combinational)
//   dout       out  assembled word, stable while dout_valid is high
//   dout_valid out  dout holds an unconsumed word
//   dout_ready in   consumer takes dout this cycle
//   shift_q    out  live shift register contents (partial word)
//   bit_cnt    out  bits accepted into the current partial word, 0..WIDTH-1

module sipo_deser #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [WIDTH-1:0]           shift_q,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

    localparam int unsigned        CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]    LastCnt = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             dout_valid_q, dout_valid_d;
    logic             last_bit;
    logic             acc;
    logic             drn;

    // Shift register contents after taking din; also the completed word on the final bit.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], din};
        end else begin
            shifted = {din, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        last_bit = (bit_cnt_q == LastCnt);
        // Only the final bit can stall: it needs the holding register to be free or
        // draining on the same edge.
        din_ready = !rst && !(last_bit && dout_valid_q && !dout_ready);
        acc       = din_valid && din_ready;
        drn       = dout_valid_q && dout_ready;

        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !drn;

        if (acc) begin
            shift_d = shifted;
            if (last_bit) begin
                bit_cnt_d    = '0;
                dout_d       = shifted;
                // A load on the draining edge keeps valid high for full-rate streaming.
                dout_valid_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser. Two instances (MSB-first and LSB-first) share the
// same stimulus. Expected words are queued when their final bit is driven and compared
// when the MSB-first instance drains a word.

module tb_sipo_deser;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       dout_ready;

    logic       din_ready_m, din_ready_l;
    logic [7:0] dout_m, dout_l;
    logic       dv_m, dv_l;
    logic [7:0] shift_m, shift_l;
    logic [2:0] cnt_m, cnt_l;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready_m),
        .dout       (dout_m),
        .dout_valid (dv_m),
        .dout_ready (dout_ready),
        .shift_q    (shift_m),
        .bit_cnt    (cnt_m)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready_l),
        .dout       (dout_l),
        .dout_valid (dv_l),
        .dout_ready (dout_ready),
        .shift_q    (shift_l),
        .bit_cnt    (cnt_l)
    );

    typedef struct {
        logic [7:0] m;
        logic [7:0] l;
    } exp_t;

    typedef struct {
        logic [7:0] tx;   // tx[7] is sent first
        logic [7:0] em;
        logic [7:0] el;
    } vec_t;

    exp_t sb[$];
    exp_t sb_e;
    vec_t vecs[4];

    int n_checks = 0;
    int n_pass   = 0;
    int stalls   = 0;
    int valid_cycles = 0;
    int vc_start;

    // Reference model of the live shift state
    logic [7:0] mdl_m, mdl_l;
    logic [2:0] mdl_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
    endtask

    task automatic model_reset();
        mdl_m   = 8'h00;
        mdl_l   = 8'h00;
        mdl_cnt = 3'd0;
    endtask

    task automatic model_shift(input logic b);
        mdl_m   = {mdl_m[6:0], b};
        mdl_l   = {b, mdl_l[7:1]};
        mdl_cnt = mdl_cnt + 3'd1;
    endtask

    // Present one bit and wait (bounded) until it is accepted; returns at posedge+1.
    task automatic send_bit(input logic b);
        bit ok;
        ok        = 1'b0;
        din       = b;
        din_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (din_ready_m) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            model_shift(b);
        end else begin
            chk("accept_timeout", 8'd0, 8'd1);
        end
        din_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] tx, input logic [7:0] em, input logic [7:0] el);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                e.m = em;
                e.l = el;
                sb.push_back(e);
            end
            send_bit(tx[i]);
        end
    endtask

    // Drain monitor: every word the consumer takes must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (dv_m) valid_cycles++;
            if (dv_m && dout_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 8'd1, 8'd0);
                end else begin
                    sb_e = sb.pop_front();
                    chk("sb_dout_msb", dout_m, sb_e.m);
                    chk("sb_dout_lsb", dout_l, sb_e.l);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;

        vecs[0] = '{tx: 8'hB2, em: 8'hB2, el: 8'h4D};
        vecs[1] = '{tx: 8'hC4, em: 8'hC4, el: 8'h23};
        vecs[2] = '{tx: 8'hA5, em: 8'hA5, el: 8'hA5};
        vecs[3] = '{tx: 8'h3C, em: 8'h3C, el: 8'h3C};

        rst        = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b1;
        dout_ready = 1'b0;
        model_reset();

        // Reset state; din_ready must be low while rst is held even with din_valid high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_din_ready", 8'(din_ready_m), 8'd0);
        chk("rst_dout_valid", 8'(dv_m), 8'd0);
        chk("rst_dout", dout_m, 8'h00);
        chk("rst_bit_cnt", 8'(cnt_m), 8'd0);
        chk("rst_shift", shift_m, 8'h00);
        rst       = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;

        // Tests 1/2: bits 1,0,1,1,0,0,1,0 with consumer always ready
        dout_ready = 1'b1;
        w = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                sb_e.m = 8'hB2;
                sb_e.l = 8'h4D;
                sb.push_back(sb_e);
            end
            send_bit(w[i]);
            if (i == 5) begin
                chk("t2_shift_msb_3bits", shift_m, 8'h05);
                chk("t2_shift_lsb_3bits", shift_l, 8'hA0);
            end
            if (i == 1) chk("t1_no_early_valid", 8'(dv_m), 8'd0);
        end
        chk("t1_valid", 8'(dv_m), 8'd1);
        chk("t1_dout_msb", dout_m, 8'hB2);
        chk("t2_dout_lsb", dout_l, 8'h4D);
        chk("t1_bit_cnt", 8'(cnt_m), 8'd0);
        chk("t1_shift_kept", shift_m, 8'hB2);
        @(posedge clk);
        #1;
        chk("t1_valid_one_cycle", 8'(dv_m), 8'd0);

        // Table-driven words, consumer ready
        for (int v = 0; v < 4; v++) begin
            send_word(vecs[v].tx, vecs[v].em, vecs[v].el);
            chk("tbl_valid", 8'(dv_m), 8'd1);
            chk("tbl_dout_msb", dout_m, vecs[v].em);
            chk("tbl_dout_lsb", dout_l, vecs[v].el);
        end
        @(posedge clk);
        #1;

        // Test 3: held word blocks only the final bit of the next word
        dout_ready = 1'b0;
        send_word(8'hB2, 8'hB2, 8'h4D);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        sb_e.m = 8'hFF;
        sb_e.l = 8'hFF;
        sb.push_back(sb_e);
        chk("t3_bit_cnt7", 8'(cnt_m), 8'd7);
        chk("t3_din_ready_low", 8'(din_ready_m), 8'd0);
        chk("t3_dout_held", dout_m, 8'hB2);
        din       = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("t3_stall_cnt", 8'(cnt_m), 8'd7);
            chk("t3_stall_dout", dout_m, 8'hB2);
            chk("t3_stall_dout_lsb", dout_l, 8'h4D);
            chk("t3_stall_valid", 8'(dv_m), 8'd1);
            chk("t3_stall_ready", 8'(din_ready_m), 8'd0);
        end
        dout_ready = 1'b1;
        #1;
        chk("t3_ready_follows", 8'(din_ready_m), 8'd1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        model_shift(1'b1);
        chk("t3_new_valid", 8'(dv_m), 8'd1);
        chk("t3_new_dout", dout_m, 8'hFF);
        chk("t3_cnt_wrap", 8'(cnt_m), 8'd0);
        @(posedge clk);
        #1;
        chk("t3_drained", 8'(dv_m), 8'd0);

        // Test 4: gaps in din_valid (1,0,0 pattern) while sending 8'h3C
        w = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                sb_e.m = 8'h3C;
                sb_e.l = 8'h3C;
                sb.push_back(sb_e);
            end
            send_bit(w[i]);
            if (i != 0) begin
                din = ~w[i];
                for (int g = 0; g < 2; g++) begin
                    @(posedge clk);
                    #1;
                    chk("t4_gap_cnt", 8'(cnt_m), 8'(mdl_cnt));
                    chk("t4_gap_shift_msb", shift_m, mdl_m);
                    chk("t4_gap_shift_lsb", shift_l, mdl_l);
                end
            end
        end
        chk("t4_dout", dout_m, 8'h3C);
        chk("t4_valid", 8'(dv_m), 8'd1);
        @(posedge clk);
        #1;

        // Test 5: three words back to back at full rate
        stalls   = 0;
        vc_start = valid_cycles;
        send_word(8'h01, 8'h01, 8'h80);
        chk("t5_w0", dout_m, 8'h01);
        send_word(8'h80, 8'h80, 8'h01);
        chk("t5_w1", dout_m, 8'h80);
        send_word(8'hFF, 8'hFF, 8'hFF);
        chk("t5_w2", dout_m, 8'hFF);
        chk("t5_w2_valid", 8'(dv_m), 8'd1);
        @(posedge clk);
        #1;
        chk("t5_no_stall", 8'(stalls), 8'd0);
        chk("t5_valid_cycles", 8'(valid_cycles - vc_start), 8'd3);

        // Test 6: reset with a held word and a partial word in flight
        dout_ready = 1'b0;
        send_word(8'h5A, 8'h5A, 8'h5A);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t6_pre_cnt", 8'(cnt_m), 8'd5);
        chk("t6_pre_valid", 8'(dv_m), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_din_ready", 8'(din_ready_m), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_reset();
        chk("t6_valid", 8'(dv_m), 8'd0);
        chk("t6_dout", dout_m, 8'h00);
        chk("t6_bit_cnt", 8'(cnt_m), 8'd0);
        chk("t6_shift", shift_m, 8'h00);
        chk("t6_shift_lsb", shift_l, 8'h00);
        dout_ready = 1'b1;
        send_word(8'hA5, 8'hA5, 8'hA5);
        chk("t6_new_word", dout_m, 8'hA5);
        chk("t6_new_word_lsb", dout_l, 8'hA5);
        chk("t6_new_valid", 8'(dv_m), 8'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
